hqm_rcfwl_gclk_rcb_en_ctrl: RTL and testbench

HQM_RCFWL_GCLK_RCB_EN_CTRL -- requirements
Module: hqm_rcfwl_gclk_rcb_en_ctrl

---
 rtl/hqm_rcfwl_gclk_rcb_pkg.sv | 20 ++
 rtl/hqm_rcfwl_gclk_dncnt.sv | 24 ++
 rtl/hqm_rcfwl_gclk_rcb_en_ctrl.sv | 138 +++++++++++++
 tb/tb_hqm_rcfwl_gclk_rcb_en_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hqm_rcfwl_gclk_rcb_pkg.sv
// Shared types and constants for the RCFWL grid-clock RCB enable controller.
package hqm_rcfwl_gclk_rcb_pkg;

    localparam int unsigned WAKE_DLY_DEF = 4;
    // Wake count must hold WAKE_DLY-1 for the full 1..15 range
    localparam int unsigned WAKE_W       = 4;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        WAKE = 2'd1,
        ON   = 2'd2,
        HYST = 2'd3
    } rcbState_t;

    // Shared counter is wide enough for either the wake or the hysteresis count
    function automatic int unsigned cntWidth(input int unsigned hystW);
        return (hystW > WAKE_W) ? hystW : WAKE_W;
    endfunction

endpackage

// File: rtl/hqm_rcfwl_gclk_dncnt.sv
// Loadable down-counter that sticks at zero instead of wrapping.
module hqm_rcfwl_gclk_dncnt #(
    parameter int unsigned W = 4
) (
    input  logic         CkGridX1N,
    input  logic         AsyncRstB,
    input  logic         Load,
    input  logic [W-1:0] LoadVal,
    input  logic         Dec,
    output logic [W-1:0] Cnt
);

    // Load has priority; decrement is ignored once the count reaches zero
    always_ff @(posedge CkGridX1N or negedge AsyncRstB) begin
        if (!AsyncRstB) begin
            Cnt <= '0;
        end else if (Load) begin
            Cnt <= LoadVal;
        end else if (Dec && (Cnt != '0)) begin
            Cnt <= Cnt - W'(1);
        end
    end

endmodule

// File: rtl/hqm_rcfwl_gclk_rcb_en_ctrl.sv
// RCB clock-gate enable controller: four-phase ClkReq/ClkAck handshake with a
// wake delay before acknowledge and idle hysteresis before gating.
// Optional feature macro: RCFWL_GCLK_RCB_FORCE_ON_EN adds the ForceOn input.
module hqm_rcfwl_gclk_rcb_en_ctrl
    import hqm_rcfwl_gclk_rcb_pkg::*;
#(
    parameter int unsigned WAKE_DLY = WAKE_DLY_DEF,
    parameter int unsigned HYST_W   = 4
) (
    input  logic              CkGridX1N,
    input  logic              AsyncRstB,
`ifdef RCFWL_GCLK_RCB_FORCE_ON_EN
    input  logic              ForceOn,
`endif
    input  logic              ClkReq,
    input  logic [HYST_W-1:0] HystCnt,
    input  logic              FdCfg,
    input  logic              RdCfg,
    output logic              RcbEn,
    output logic              Fd,
    output logic              Rd,
    output logic              ClkAck,
    output logic              Active
);

    localparam int unsigned CNT_W = cntWidth(HYST_W);

    rcbState_t        state;
    rcbState_t        stateNxt;
    logic             armed;
    logic             forceOn;
    logic             cntLoad;
    logic             cntDec;
    logic [CNT_W-1:0] cntLoadVal;
    logic [CNT_W-1:0] cnt;
    logic             rcbEnNxt;
    logic             clkAckNxt;

`ifdef RCFWL_GCLK_RCB_FORCE_ON_EN
    assign forceOn = ForceOn;
`else
    assign forceOn = 1'b0;
`endif

    // Shared wake / hysteresis counter
    hqm_rcfwl_gclk_dncnt #(
        .W (CNT_W)
    ) uDnCnt (
        .CkGridX1N (CkGridX1N),
        .AsyncRstB (AsyncRstB),
        .Load      (cntLoad),
        .LoadVal   (cntLoadVal),
        .Dec       (cntDec),
        .Cnt       (cnt)
    );

    // Next-state, counter control and next output values
    always_comb begin
        stateNxt   = state;
        cntLoad    = 1'b0;
        cntDec     = 1'b0;
        cntLoadVal = '0;
        if (forceOn) begin
            stateNxt = ON;
        end else begin
            case (state)
                OFF: begin
                    if (ClkReq) begin
                        stateNxt   = WAKE;
                        cntLoad    = 1'b1;
                        cntLoadVal = CNT_W'(WAKE_DLY - 1);
                    end
                end
                WAKE: begin
                    if (cnt == '0) begin
                        stateNxt = ClkReq ? ON : HYST;
                    end else begin
                        cntDec = 1'b1;
                    end
                end
                ON: begin
                    if (!ClkReq) begin
                        if (HystCnt == '0) begin
                            stateNxt = OFF;
                        end else begin
                            stateNxt   = HYST;
                            cntLoad    = 1'b1;
                            cntLoadVal = CNT_W'(HystCnt - HYST_W'(1));
                        end
                    end
                end
                HYST: begin
                    if (ClkReq) begin
                        stateNxt = ON;
                    end else if (cnt == '0) begin
                        stateNxt = OFF;
                    end else begin
                        cntDec = 1'b1;
                    end
                end
                default: stateNxt = OFF;
            endcase
        end
        // First edge after reset release only arms the controller
        if (!armed) begin
            stateNxt = state;
            cntLoad  = 1'b0;
            cntDec   = 1'b0;
        end
        rcbEnNxt  = (stateNxt != OFF);
        clkAckNxt = (stateNxt == ON);
    end

    // State, arming flag and registered outputs
    always_ff @(posedge CkGridX1N or negedge AsyncRstB) begin
        if (!AsyncRstB) begin
            state  <= OFF;
            armed  <= 1'b0;
            RcbEn  <= 1'b0;
            ClkAck <= 1'b0;
            Active <= 1'b0;
            Fd     <= 1'b0;
            Rd     <= 1'b0;
        end else begin
            armed  <= 1'b1;
            state  <= stateNxt;
            RcbEn  <= rcbEnNxt;
            ClkAck <= clkAckNxt;
            Active <= rcbEnNxt;
            // LCP bits only follow config while the clock is gated off
            if (state == OFF) begin
                Fd <= FdCfg;
                Rd <= RdCfg;
            end
        end
    end

endmodule

// File: tb/tb_hqm_rcfwl_gclk_rcb_en_ctrl.sv
// Self-checking bench for hqm_rcfwl_gclk_rcb_en_ctrl: directed vector table,
// mid-hysteresis reset sequence and randomized run against a reference model.
module tb_hqm_rcfwl_gclk_rcb_en_ctrl;

    localparam int WAKE_DLY = 4;
    localparam int HYST_W   = 4;

    logic              CkGridX1N = 1'b0;
    logic              AsyncRstB = 1'b1;
    logic              ClkReq    = 1'b0;
    logic [HYST_W-1:0] HystCnt   = '0;
    logic              FdCfg     = 1'b0;
    logic              RdCfg     = 1'b0;
    logic              RcbEn;
    logic              Fd;
    logic              Rd;
    logic              ClkAck;
    logic              Active;
`ifdef RCFWL_GCLK_RCB_FORCE_ON_EN
    logic              ForceOn   = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    hqm_rcfwl_gclk_rcb_en_ctrl #(
        .WAKE_DLY (WAKE_DLY),
        .HYST_W   (HYST_W)
    ) dut (
        .CkGridX1N (CkGridX1N),
        .AsyncRstB (AsyncRstB),
`ifdef RCFWL_GCLK_RCB_FORCE_ON_EN
        .ForceOn   (ForceOn),
`endif
        .ClkReq    (ClkReq),
        .HystCnt   (HystCnt),
        .FdCfg     (FdCfg),
        .RdCfg     (RdCfg),
        .RcbEn     (RcbEn),
        .Fd        (Fd),
        .Rd        (Rd),
        .ClkAck    (ClkAck),
        .Active    (Active)
    );

    always #5 CkGridX1N = ~CkGridX1N;

    typedef struct {
        logic       req;
        logic [3:0] hyst;
        logic       fd;
        logic       rd;
        logic       eEn;
        logic       eAck;
        logic       eFd;
        logic       eRd;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic req, input logic [3:0] hyst, input logic fd, input logic rd,
                          input logic eEn, input logic eAck, input logic eFd, input logic eRd);
        vec_t v;
        v.req = req; v.hyst = hyst; v.fd = fd; v.rd = rd;
        v.eEn = eEn; v.eAck = eAck; v.eFd = eFd; v.eRd = eRd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] t=%0t got=%0b exp=%0b", nm, idx, $time, act, exp);
        end
    endtask

    task automatic chkAll(input string tag, input int idx, input logic eEn, input logic eAck,
                          input logic eFd, input logic eRd);
        chk({tag, ".RcbEn"},  idx, RcbEn,  eEn);
        chk({tag, ".ClkAck"}, idx, ClkAck, eAck);
        chk({tag, ".Active"}, idx, Active, eEn);
        chk({tag, ".Fd"},     idx, Fd,     eFd);
        chk({tag, ".Rd"},     idx, Rd,     eRd);
    endtask

    // Reference model: gate/ack flags plus remaining-cycle counts for the
    // wake phase and the idle (hysteresis) phase; -1 means phase not active.
    bit mGate, mAck, mFd, mRd;
    int mWake, mIdle, mEdges;

    task automatic modelReset();
        mGate = 0; mAck = 0; mFd = 0; mRd = 0;
        mWake = -1; mIdle = -1; mEdges = 0;
    endtask

    task automatic modelStep(input bit req, input int hyst, input bit fd, input bit rd);
        bit wasOff;
        wasOff = !mGate;
        if (wasOff) begin
            mFd = fd;
            mRd = rd;
        end
        if (mEdges == 0) begin
            mEdges = 1;
        end else if (!mGate) begin
            if (req) begin
                mGate = 1;
                mWake = WAKE_DLY - 1;
            end
        end else if (mWake >= 0) begin
            if (mWake == 0) begin
                mWake = -1;
                if (req) mAck = 1;
                else     mIdle = 0;
            end else begin
                mWake--;
            end
        end else if (mAck) begin
            if (!req) begin
                mAck = 0;
                if (hyst == 0) mGate = 0;
                else           mIdle = hyst - 1;
            end
        end else begin
            if (req) begin
                mAck  = 1;
                mIdle = -1;
            end else if (mIdle == 0) begin
                mGate = 0;
                mIdle = -1;
            end else begin
                mIdle--;
            end
        end
    endtask

    task automatic runCycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CkGridX1N);
            @(negedge CkGridX1N);
        end
    endtask

    initial begin
        // Directed vectors, one per clock after reset release
        //     req hyst fd rd | En Ack Fd Rd
        addVec(1, 3, 1, 0,  0, 0, 1, 0);   // arming edge, no transition
        addVec(1, 3, 1, 0,  1, 0, 1, 0);   // OFF -> WAKE
        addVec(1, 3, 0, 1,  1, 0, 1, 0);
        addVec(1, 3, 0, 1,  1, 0, 1, 0);
        addVec(1, 3, 0, 1,  1, 0, 1, 0);
        addVec(1, 3, 0, 1,  1, 1, 1, 0);   // ack WAKE_DLY+1 cycles after request
        addVec(1, 3, 0, 1,  1, 1, 1, 0);
        addVec(0, 3, 0, 1,  1, 0, 1, 0);   // HYST 3
        addVec(0, 3, 0, 1,  1, 0, 1, 0);
        addVec(0, 3, 0, 1,  1, 0, 1, 0);
        addVec(0, 3, 0, 1,  0, 0, 1, 0);   // gated off, LCP still held
        addVec(0, 3, 0, 1,  0, 0, 0, 1);   // LCP follows config in OFF
        addVec(1, 5, 1, 0,  1, 0, 1, 0);
        addVec(1, 5, 0, 1,  1, 0, 1, 0);
        addVec(1, 5, 0, 1,  1, 0, 1, 0);
        addVec(1, 5, 0, 1,  1, 0, 1, 0);
        addVec(1, 5, 0, 1,  1, 1, 1, 0);
        addVec(0, 5, 0, 1,  1, 0, 1, 0);   // HYST 5
        addVec(0, 5, 0, 1,  1, 0, 1, 0);
        addVec(1, 5, 0, 1,  1, 1, 1, 0);   // re-request: immediate ack
        addVec(0, 0, 0, 1,  0, 0, 1, 0);   // HystCnt=0: straight to OFF
        addVec(0, 0, 0, 1,  0, 0, 0, 1);
        addVec(1, 0, 0, 1,  1, 0, 0, 1);   // WAKE with request dropped
        addVec(0, 0, 1, 0,  1, 0, 0, 1);
        addVec(0, 0, 1, 0,  1, 0, 0, 1);
        addVec(0, 0, 1, 0,  1, 0, 0, 1);
        addVec(0, 0, 1, 0,  1, 0, 0, 1);   // WAKE -> HYST, no ack
        addVec(0, 0, 1, 0,  0, 0, 0, 1);
        addVec(1, 1, 1, 0,  1, 0, 1, 0);
        addVec(1, 1, 0, 1,  1, 0, 1, 0);
        addVec(1, 1, 0, 1,  1, 0, 1, 0);
        addVec(1, 1, 0, 1,  1, 0, 1, 0);
        addVec(1, 1, 0, 1,  1, 1, 1, 0);
        addVec(0, 1, 0, 1,  1, 0, 1, 0);   // HYST with count already 0
        addVec(1, 1, 0, 1,  1, 1, 1, 0);   // request wins over expiry
        addVec(0, 1, 0, 1,  1, 0, 1, 0);
        addVec(0, 1, 0, 1,  0, 0, 1, 0);
        addVec(0, 1, 0, 1,  0, 0, 0, 1);

        // Reset state
        #1 AsyncRstB = 1'b0;
        #1 chkAll("rst", 0, 0, 0, 0, 0);
        @(negedge CkGridX1N);
        @(negedge CkGridX1N);
        chkAll("rstHeld", 0, 0, 0, 0, 0);
        AsyncRstB = 1'b1;

        // Directed table
        foreach (vecs[i]) begin
            ClkReq  = vecs[i].req;
            HystCnt = vecs[i].hyst;
            FdCfg   = vecs[i].fd;
            RdCfg   = vecs[i].rd;
            @(posedge CkGridX1N);
            @(negedge CkGridX1N);
            chkAll("vec", i, vecs[i].eEn, vecs[i].eAck, vecs[i].eFd, vecs[i].eRd);
        end

        // Reset in the middle of HYST drops enable and ack at once
        ClkReq = 1'b1; HystCnt = 4'd3; FdCfg = 1'b1; RdCfg = 1'b1;
        runCycles(6);
        chkAll("preRstOn", 0, 1, 1, 1, 1);
        ClkReq = 1'b0;
        runCycles(1);
        chkAll("preRstHyst", 0, 1, 0, 1, 1);
        #2 AsyncRstB = 1'b0;
        #1 chkAll("midHystRst", 0, 0, 0, 0, 0);
        @(negedge CkGridX1N);
        AsyncRstB = 1'b1;

`ifdef RCFWL_GCLK_RCB_FORCE_ON_EN
        // ForceOn from OFF with no request
        ClkReq = 1'b0; HystCnt = 4'd2;
        runCycles(2);
        chkAll("forceIdle", 0, 0, 0, 1, 1);
        ForceOn = 1'b1;
        runCycles(1);
        chk("force.RcbEn", 0, RcbEn, 1'b1);
        chk("force.ClkAck", 0, ClkAck, 1'b1);
        ForceOn = 1'b0;
        runCycles(1);
        chk("forceDrop.ClkAck", 0, ClkAck, 1'b0);
        chk("forceDrop.RcbEn", 0, RcbEn, 1'b1);
        AsyncRstB = 1'b0;
        @(negedge CkGridX1N);
        AsyncRstB = 1'b1;
`endif

        // Randomized run against the reference model
        modelReset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                #2 AsyncRstB = 1'b0;
                #1 chkAll("rndRst", i, 0, 0, 0, 0);
                modelReset();
                @(negedge CkGridX1N);
                AsyncRstB = 1'b1;
            end else begin
                if ($urandom_range(0, 7) == 0) ClkReq = ~ClkReq;
                if ($urandom_range(0, 15) == 0) HystCnt = HYST_W'($urandom_range(0, 4));
                FdCfg = 1'($urandom_range(0, 1));
                RdCfg = 1'($urandom_range(0, 1));
                @(posedge CkGridX1N);
                modelStep(ClkReq, int'(HystCnt), FdCfg, RdCfg);
                @(negedge CkGridX1N);
                chkAll("rnd", i, mGate, mAck, mFd, mRd);
                chk("rnd.ackImpliesEn", i, (!ClkAck) || RcbEn, 1'b1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
